// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Holds the state encoding, the BCD digit limit and the prescaler width function.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Smallest width able to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control pulses in, BCD digits and status flags out.
// master drives the pulses and watches the display; slave is the timer.
interface bcd_countdown_timer_if;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] tens_digit;
  logic [3:0] ones_digit;
  logic       running;
  logic       timeout;

  modport master (
    output load, start, pause,
    input  tens_digit, ones_digit, running, timeout
  );

  modport slave (
    input  load, start, pause,
    output tens_digit, ones_digit, running, timeout
  );
endinterface

// File: rtl/bcd_countdown_timer_tick_gen.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while en is high, tick on the terminal count.
// Holds its value whenever en is low, so a suppressed terminal tick fires on the next enabled cycle.
module tick_gen
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en && w_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) with run/pause FSM and timeout flag.
// All outputs registered; pulse inputs take effect on the next edge, no backpressure.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int START_TENS    = 9,
  parameter int START_ONES    = 9
) (
  input logic                  clk,
  input logic                  rst,
  bcd_countdown_timer_if.slave bus
);

  if (START_TENS < 0 || START_TENS > 9 || START_ONES < 0 || START_ONES > 9) begin : g_bad_start
    $error("bcd_countdown_timer: START_TENS/START_ONES must be BCD digits 0-9");
  end
  if (TICKS_PER_SEC < 2) begin : g_bad_ticks
    $error("bcd_countdown_timer: TICKS_PER_SEC must be >= 2");
  end

  localparam logic [3:0] START_T    = 4'(START_TENS);
  localparam logic [3:0] START_O    = 4'(START_ONES);
  localparam bit         START_ZERO = (START_TENS == 0) && (START_ONES == 0);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_tens, w_tens_nxt;
  logic [3:0] r_ones, w_ones_nxt;
  logic       w_clr;
  logic       w_en;
  logic       w_tick;

  // A pause or load on the terminal cycle must freeze the prescaler rather than tick.
  assign w_en = (r_state == ST_RUN) && !bus.pause && !bus.load;

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tens  <= START_T;
      r_ones  <= START_O;
    end else begin
      r_state <= w_state_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_clr       = 1'b0;

    if (bus.load) begin
      w_state_nxt = ST_IDLE;
      w_tens_nxt  = START_T;
      w_ones_nxt  = START_O;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_state_nxt = START_ZERO ? ST_DONE : ST_RUN;
            w_clr       = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_tick) begin
            if (r_ones != 4'd0) begin
              w_ones_nxt = r_ones - 4'd1;
            end else begin
              w_ones_nxt = BCD_MAX;
              w_tens_nxt = r_tens - 4'd1;
            end
            // Going 01 -> 00 finishes on the same edge so timeout lines up with the 00 display.
            if (r_tens == 4'd0 && r_ones == 4'd1) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_PAUSED: begin
          if (!bus.pause && bus.start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.tens_digit = r_tens;
  assign bus.ones_digit = r_ones;
  assign bus.running    = (r_state == ST_RUN);
  assign bus.timeout    = (r_state == ST_DONE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven bench for bcd_countdown_timer with TICKS_PER_SEC=4 and three START values.
// Rows push expected outputs to a scoreboard queue; entries are popped and checked after each edge.
module tb_bcd_countdown_timer;

  logic clk;
  logic rst_a, rst_b, rst_c;

  bcd_countdown_timer_if if_a ();
  bcd_countdown_timer_if if_b ();
  bcd_countdown_timer_if if_c ();

  bcd_countdown_timer #(.TICKS_PER_SEC(4), .START_TENS(9), .START_ONES(9)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a.slave)
  );
  bcd_countdown_timer #(.TICKS_PER_SEC(4), .START_TENS(0), .START_ONES(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b.slave)
  );
  bcd_countdown_timer #(.TICKS_PER_SEC(4), .START_TENS(0), .START_ONES(0)) dut_c (
    .clk(clk), .rst(rst_c), .bus(if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    bit          rst, load, start, pause;
    int          reps;
    logic [3:0]  t, o;
    bit          run, to;
  } vec_t;

  typedef struct {
    int          dut;
    int          row;
    logic [3:0]  t, o;
    bit          run, to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input int d, input bit r, input bit l, input bit s, input bit p,
                              input int reps, input int t, input int o, input bit run, input bit to);
    vec_t v;
    v.dut = d; v.rst = r; v.load = l; v.start = s; v.pause = p; v.reps = reps;
    v.t = 4'(t); v.o = 4'(o); v.run = run; v.to = to;
    vecs.push_back(v);
  endfunction

  // Counting down on dut A from value 'from' (prescaler at 0) to value 'to', one second per step.
  function automatic void add_count(input int from, input int to);
    for (int v = from - 1; v >= to; v--) begin
      add(0, 0, 0, 0, 0, 3, (v + 1) / 10, (v + 1) % 10, 1, 0);
      add(0, 0, 0, 0, 0, 1, v / 10, v % 10, v != 0, v == 0);
    end
  endfunction

  task automatic drive(input int d, input bit r, input bit l, input bit s, input bit p);
    rst_a = (d == 0) && r; if_a.load = (d == 0) && l; if_a.start = (d == 0) && s; if_a.pause = (d == 0) && p;
    rst_b = (d == 1) && r; if_b.load = (d == 1) && l; if_b.start = (d == 1) && s; if_b.pause = (d == 1) && p;
    rst_c = (d == 2) && r; if_c.load = (d == 2) && l; if_c.start = (d == 2) && s; if_c.pause = (d == 2) && p;
  endtask

  task automatic check_one();
    exp_t       e;
    logic [3:0] at, ao;
    logic       ar, ato;
    e = sb.pop_front();
    case (e.dut)
      0:       begin at = if_a.tens_digit; ao = if_a.ones_digit; ar = if_a.running; ato = if_a.timeout; end
      1:       begin at = if_b.tens_digit; ao = if_b.ones_digit; ar = if_b.running; ato = if_b.timeout; end
      default: begin at = if_c.tens_digit; ao = if_c.ones_digit; ar = if_c.running; ato = if_c.timeout; end
    endcase
    n_chk++;
    if ({at, ao, ar, ato} !== {e.t, e.o, e.run, e.to}) begin
      n_fail++;
      $display("FAIL row%0d dut%0d: got %0d/%0d run=%0b to=%0b, want %0d/%0d run=%0b to=%0b",
               e.row, e.dut, at, ao, ar, ato, e.t, e.o, e.run, e.to);
    end
  endtask

  initial begin
    exp_t e;

    // START=00: start goes straight to DONE
    add(2, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    add(2, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 3, 0, 0, 0, 1);
    // START=02: two seconds to DONE, then DONE ignores start/pause, load exits
    add(1, 1, 0, 0, 0, 2, 0, 2, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 2, 1, 0);
    add(1, 0, 0, 0, 0, 3, 0, 2, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 3, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 3, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 1, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 2, 0, 2, 0, 0);
    // START=99: reset and idle
    add(0, 1, 0, 0, 0, 2, 9, 9, 0, 0);
    add(0, 0, 0, 0, 0, 10, 9, 9, 0, 0);
    // run to 97, pause on the terminal cycle, resume ticks immediately
    add(0, 0, 0, 1, 0, 1, 9, 9, 1, 0);
    add_count(99, 97);
    add(0, 0, 0, 0, 0, 3, 9, 7, 1, 0);
    add(0, 0, 0, 0, 1, 1, 9, 7, 0, 0);
    add(0, 0, 0, 0, 0, 20, 9, 7, 0, 0);
    add(0, 0, 0, 1, 0, 1, 9, 7, 1, 0);
    add(0, 0, 0, 0, 0, 1, 9, 6, 1, 0);
    // ones borrow into tens
    add_count(96, 89);
    add(0, 0, 0, 0, 0, 3, 8, 9, 1, 0);
    // start+pause together in RUN: pause wins
    add(0, 0, 0, 1, 1, 1, 8, 9, 0, 0);
    add(0, 0, 0, 1, 0, 1, 8, 9, 1, 0);
    add(0, 0, 0, 0, 0, 1, 8, 8, 1, 0);
    // reset mid-run at 45, then first decrement exactly four cycles after start
    add_count(88, 45);
    add(0, 0, 0, 0, 0, 2, 4, 5, 1, 0);
    add(0, 1, 0, 0, 0, 1, 9, 9, 0, 0);
    add(0, 0, 0, 1, 0, 1, 9, 9, 1, 0);
    add(0, 0, 0, 0, 0, 3, 9, 9, 1, 0);
    add(0, 0, 0, 0, 0, 1, 9, 8, 1, 0);
    // all the way down, hold at 00, load+start in DONE reloads to IDLE
    add_count(98, 0);
    add(0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 9, 9, 0, 0);
    add(0, 0, 0, 0, 0, 3, 9, 9, 0, 0);

    drive(-1, 0, 0, 0, 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        drive(vecs[i].dut, vecs[i].rst, vecs[i].load, vecs[i].start, vecs[i].pause);
        e.dut = vecs[i].dut; e.row = i;
        e.t = vecs[i].t; e.o = vecs[i].o; e.run = vecs[i].run; e.to = vecs[i].to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
      end
    end
    drive(-1, 0, 0, 0, 0);

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
